sbox_array: RTL

Multi-lane, pipelined AES byte-substitution unit with a valid/ready handshake. Substitutes every byte of an input word through the FIPS-197 forward S-box or, optionally, the inverse S-box, and runs at full throughput with downstream backpressure. Sits between the round-state register and ShiftRows / InvShiftRows in both the encrypt and decrypt datapaths, and replaces single-byte lookups with one parametrised block.

---
 rtl/sbox_array.sv | 105 ++++++++++
 1 files changed

// File: rtl/sbox_array.sv
// LANES-wide, two-stage AES byte substitution (S-box / inverse S-box) with valid/ready flow control.
// Optional inverse table: define SBOX_INV_EN; otherwise every word uses the forward S-box.
module sbox_array #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               inv,
  input  logic [8*LANES-1:0] data_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [8*LANES-1:0] data_out,
  output logic               inv_out,
  output logic [CNT_W-1:0]   word_cnt
);

  // Tables are stored row-major with entry 0x00 in the most significant byte.
  localparam logic [2047:0] FWD_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SBOX_INV_EN
  localparam logic [2047:0] INV_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    return INV_TAB[2047 - 8*int'(b) -: 8];
  endfunction
`endif

  function automatic logic [7:0] fwd_byte(input logic [7:0] b);
    return FWD_TAB[2047 - 8*int'(b) -: 8];
  endfunction

  logic               s1_valid;
  logic               s1_inv;
  logic [8*LANES-1:0] s1_data;
  logic [8*LANES-1:0] sub_data;
  logic               in_xfer;
  logic               s2_load;

  assign ready_out = !s1_valid || !valid_out || ready_in;
  assign in_xfer   = valid_in && ready_out;
  assign s2_load   = s1_valid && (!valid_out || ready_in);

  always_comb begin
    sub_data = '0;
    for (int k = 0; k < LANES; k++) begin
`ifdef SBOX_INV_EN
      sub_data[8*k +: 8] = s1_inv ? inv_byte(s1_data[8*k +: 8]) : fwd_byte(s1_data[8*k +: 8]);
`else
      sub_data[8*k +: 8] = fwd_byte(s1_data[8*k +: 8]);
`endif
    end
  end

  // S2 may refill in the same edge it hands its word downstream, keeping full throughput.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_inv    <= 1'b0;
      s1_data   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      inv_out   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (s2_load) begin
        valid_out <= 1'b1;
        data_out  <= sub_data;
        inv_out   <= s1_inv;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end

      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_data  <= data_in;
        s1_inv   <= inv;
        word_cnt <= word_cnt + CNT_W'(1);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
